spi_master_sr: RTL and testbench
================================

Name: spi_master_sr

Overview:
- SPI master (mode 0, MSB first) that drives the 48-bit `shiftreg` chain.
- Generates `spi_clk` at 1 MHz from the system clock using a half-period prescaler.
- Asserts slave-select for one word, shifts `tx_data` out on `spi_mosi`, and captures `spi_miso` into `rx_data`.
- Enforces an inter-word blank gap so that `shiftreg` sees discrete frames.

Parameters:
- WIDTH, 48: bits per frame.
- HALF_DIV, 4: system clocks per `spi_clk` half-period. Must be ≥1. The value 4 gives 1 MHz from 8 MHz.
- GAP_CYCLES, 8: system clocks with `spi_ss_n` high between frames. 0 means no gap.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request a frame; honoured only when busy=0.
- tx_data  input  WIDTH  word to send; sampled on the accepted start cycle.
- busy  output  1  high from the cycle after accept until the gap ends.
- done  output  1  one-cycle pulse when rx_data is updated.
- rx_data  output  WIDTH  last received word.
- spi_clk  output  1  SPI clock; idles low.
- spi_mosi  output  1  serial data out.
- spi_miso  input  1  serial data in.
- spi_ss_n  output  1  active-low slave select.

Behaviour:
- Reset (reset=0 at posedge): takes priority over everything, including mid-frame.
  - State goes to IDLE.
  - spi_clk=0, spi_ss_n=1, spi_mosi=0, busy=0, done=0, rx_data=0.
  - Bit and divide counters cleared.
  - An aborted frame produces no done pulse and does not update rx_data.
- All outputs are registered.
- States: IDLE, LEAD, CLK_HI, CLK_LO, TRAIL, GAP. Each of LEAD, CLK_HI, CLK_LO, TRAIL lasts exactly HALF_DIV cycles.
- IDLE:
  - start=1 → load tx_data into the tx shift register, set bit_cnt=WIDTH-1.
  - Same edge: spi_ss_n←0, spi_mosi←tx_data[WIDTH-1], busy←1, go to LEAD.
- LEAD: spi_clk stays low. At the end of the phase, spi_clk←1 and go to CLK_HI.
- CLK_HI:
  - MISO sampling: on the same edge that drives spi_clk←1, spi_miso is shifted into the LSB of the rx shift register. This captures the pre-edge value and matches the slave's rising-edge shift.
  - At the end of the phase, spi_clk←0.
  - If bit_cnt=0, go to TRAIL.
  - Otherwise shift tx left, spi_mosi←next bit, bit_cnt−1, go to CLK_LO.
- CLK_LO: at the end of the phase, spi_clk←1 (with MISO sample) and go to CLK_HI.
- TRAIL: at the end of the phase:
  - spi_ss_n←1, rx_data←rx shift register, done←1 for one cycle, spi_mosi←0.
  - Go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: after GAP_CYCLES cycles, busy←0 and go to IDLE.
- Frame timing:
  - spi_ss_n is low for exactly (2·WIDTH+1)·HALF_DIV cycles.
  - WIDTH rising edges of spi_clk per frame.
  - spi_clk is never high while spi_ss_n is high.
- Handshake:
  - start while busy=1 is ignored, not queued.
  - start on the first cycle with busy=0 is accepted, which gives back-to-back frames.
  - tx_data changes after accept do not affect the frame in flight.
- Width rules:
  - bit_cnt is $clog2(WIDTH) bits.
  - The divide counter is $clog2(HALF_DIV+1) bits and wraps to 0 at each phase change.
  - The gap counter is sized for GAP_CYCLES.

Optional Feature:
- Macro: SPI_LATCH_EN.
- Defined:
  - Adds output port spi_latch (1 bit, reset 0).
  - spi_latch is high for HALF_DIV cycles starting on the edge where spi_ss_n rises, to strobe the parallel output register of the shift chain.
  - GAP_CYCLES is internally forced to at least HALF_DIV.
- Undefined: no port and no logic; behaviour exactly as above.

Decomposition:
- Package spi_pkg holds:
  - typedef enum spi_state_t {IDLE, LEAD, CLK_HI, CLK_LO, TRAIL, GAP}
  - localparam SPI_FRAME_W=48
  - localparam SPI_HALF_DIV_1MHZ=4
- One sub-module, spi_clk_div:
  - Half-period counter with a synchronous clear.
  - Emits a one-cycle phase_end tick every HALF_DIV cycles.
  - Cleared on each state change.

Test Plan:
- Reset/idle: hold reset=0 for 5 cycles, release with no start → spi_clk=0, spi_ss_n=1, spi_mosi=0, busy=0, done=0, rx_data=0 throughout.
- Single frame, WIDTH=8, HALF_DIV=2, tx_data=8'hA5, spi_miso looped to spi_mosi:
  - spi_ss_n low for 34 cycles.
  - 8 spi_clk rising edges; MOSI pattern 1,0,1,0,0,1,0,1.
  - done pulses once; rx_data=8'hA5.
- Default 48-bit frame, tx_data=48'h01FFFFFFFFFF, driving a `shiftreg` #(48) model:
  - Its regout equals 48'h01FFFFFFFFFF after the frame.
  - spi_ss_n low for 388 cycles.
- Start while busy (start pulsed mid-frame and during GAP) → ignored; exactly one done; busy falls GAP_CYCLES after done.
- Reset mid-frame (reset=0 during CLK_HI of bit 20) → next edge spi_ss_n=1, spi_clk=0, no done, rx_data unchanged at 0; a subsequent start runs a full clean frame.
- Back-to-back with GAP_CYCLES=0 and start held high → consecutive frames; spi_ss_n high for exactly 1 cycle between them; with SPI_LATCH_EN, spi_latch is high for HALF_DIV cycles after each frame.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI master driving the
// shiftreg chain.
//   spi_state_t       - master FSM states
//   SPI_FRAME_W       - default frame width (length of the shiftreg chain)
//   SPI_HALF_DIV_1MHZ - half-period divide for a 1 MHz spi_clk from 8 MHz
//   spi_max()         - elaboration-time maximum of two values
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        CLK_HI,
        CLK_LO,
        TRAIL,
        GAP
    } spi_state_t;

    localparam int unsigned SPI_FRAME_W       = 48;
    localparam int unsigned SPI_HALF_DIV_1MHZ = 4;

    function automatic int unsigned spi_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period prescaler for the SPI master.
// Counts system clocks and raises phase_end on the last cycle of each
// HALF_DIV-cycle phase. A synchronous clear restarts the count so that
// every FSM state begins a fresh phase.
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-low reset
//   clear     - restart the phase count on the next edge
//   phase_end - high on the final cycle of the current phase
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned HALF_DIV = SPI_HALF_DIV_1MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic phase_end
);

    localparam int unsigned CNT_W = $clog2(HALF_DIV + 1);

    logic [CNT_W-1:0] cnt;

    assign phase_end = (cnt == CNT_W'(HALF_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_sr.sv
// spi_master_sr: SPI master (mode 0, MSB first) for the shiftreg chain.
// One start sends tx_data as a WIDTH-bit frame under spi_ss_n, captures
// spi_miso into rx_data, then holds spi_ss_n high for a blank gap so the
// chain sees discrete frames.
// Ports:
//   clk, reset       - system clock, synchronous active-low reset
//   start, tx_data   - frame request and word (sampled on accept, busy=0)
//   busy             - frame or gap in progress
//   done, rx_data    - one-cycle pulse when rx_data takes the received word
//   spi_clk, spi_mosi, spi_miso, spi_ss_n - SPI bus (spi_clk idles low)
//   spi_latch        - only with SPI_LATCH_EN: HALF_DIV-cycle strobe from
//                      the edge where spi_ss_n rises
// Optional feature macro: SPI_LATCH_EN
module spi_master_sr
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH      = SPI_FRAME_W,
    parameter int unsigned HALF_DIV   = SPI_HALF_DIV_1MHZ,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_ss_n
`ifdef SPI_LATCH_EN
    ,
    output logic             spi_latch
`endif
);

`ifdef SPI_LATCH_EN
    // The latch strobe runs inside the gap, so the gap must cover it.
    localparam int unsigned GAP_EFF = spi_max(GAP_CYCLES, HALF_DIV);
`else
    localparam int unsigned GAP_EFF = GAP_CYCLES;
`endif
    localparam int unsigned GAP_LAST = (GAP_EFF > 0) ? GAP_EFF - 1 : 0;
    localparam int unsigned GAP_W    = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
    localparam int unsigned BIT_W    = $clog2(WIDTH);

    spi_state_t       state, state_nxt;
    logic [WIDTH-1:0] tx_sr, rx_sr;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             phase_end, div_clear;
    logic             accept, sample, clk_fall, shift, finish, gap_end;

    // Every state change starts a fresh half-period.
    assign div_clear = (state_nxt != state);

    spi_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .clear     (div_clear),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        clk_fall  = 1'b0;
        shift     = 1'b0;
        finish    = 1'b0;
        gap_end   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = LEAD;
                end
            end
            LEAD, CLK_LO: begin
                if (phase_end) begin
                    sample    = 1'b1;
                    state_nxt = CLK_HI;
                end
            end
            CLK_HI: begin
                if (phase_end) begin
                    clk_fall = 1'b1;
                    if (bit_cnt == '0) begin
                        state_nxt = TRAIL;
                    end else begin
                        shift     = 1'b1;
                        state_nxt = CLK_LO;
                    end
                end
            end
            TRAIL: begin
                if (phase_end) begin
                    finish    = 1'b1;
                    state_nxt = (GAP_EFF == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_LAST)) begin
                    gap_end   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || state != GAP) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_ss_n <= 1'b1;
        end else begin
            done <= 1'b0;
            if (accept) begin
                tx_sr    <= tx_data;
                bit_cnt  <= BIT_W'(WIDTH - 1);
                spi_ss_n <= 1'b0;
                spi_mosi <= tx_data[WIDTH-1];
                busy     <= 1'b1;
            end
            // MISO is taken on the edge that raises spi_clk, i.e. the value
            // the slave held before its own rising-edge shift.
            if (sample) begin
                spi_clk <= 1'b1;
                rx_sr   <= {rx_sr[WIDTH-2:0], spi_miso};
            end
            if (clk_fall) begin
                spi_clk <= 1'b0;
            end
            if (shift) begin
                tx_sr    <= tx_sr << 1;
                spi_mosi <= tx_sr[WIDTH-2];
                bit_cnt  <= bit_cnt - 1'b1;
            end
            if (finish) begin
                spi_ss_n <= 1'b1;
                spi_mosi <= 1'b0;
                rx_data  <= rx_sr;
                done     <= 1'b1;
                if (GAP_EFF == 0) begin
                    busy <= 1'b0;
                end
            end
            if (gap_end) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef SPI_LATCH_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            spi_latch <= 1'b0;
        end else if (finish) begin
            spi_latch <= 1'b1;
        end else if (state == GAP && gap_cnt == GAP_W'(HALF_DIV - 1)) begin
            spi_latch <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_sr.sv
// tb_spi_master_sr: scoreboard bench for spi_master_sr.
// Instance 0: WIDTH=8, HALF_DIV=2, GAP_CYCLES=0, MISO looped to MOSI.
// Instance 1: defaults (48/4/8) driving a behavioural 48-bit shiftreg.
module tb_spi_master_sr;

    typedef struct {
        logic [47:0] rx;
        logic [47:0] pat;
        logic [47:0] reg_o;
        int          low;
        int          edges;
    } exp_t;

    logic        clk = 1'b0;
    logic        r8, r48, start8, start48;
    logic [7:0]  tx8, rx8;
    logic [47:0] tx48, rx48;
    logic        sclk_a [2];
    logic        ss_a   [2];
    logic        mosi_a [2];
    logic        done_a [2];
    logic        busy_a [2];
    logic [47:0] rx_a   [2];
    logic [47:0] chain, regout, chain_val;
    logic        chain_ld = 1'b0;
    logic        miso48;
    int          total = 0, bad = 0, clk_viol = 0;
    exp_t        q0[$], q1[$];

`ifdef SPI_LATCH_EN
    logic latch8, latch48;
`endif

    assign rx_a[0] = {40'b0, rx8};
    assign rx_a[1] = rx48;
    assign miso48  = chain[47];

    initial forever #5 clk = ~clk;

    spi_master_sr #(
        .WIDTH      (8),
        .HALF_DIV   (2),
        .GAP_CYCLES (0)
    ) dut8 (
        .clk      (clk),
        .reset    (r8),
        .start    (start8),
        .tx_data  (tx8),
        .busy     (busy_a[0]),
        .done     (done_a[0]),
        .rx_data  (rx8),
        .spi_clk  (sclk_a[0]),
        .spi_mosi (mosi_a[0]),
        .spi_miso (mosi_a[0]),
        .spi_ss_n (ss_a[0])
`ifdef SPI_LATCH_EN
        ,
        .spi_latch (latch8)
`endif
    );

    spi_master_sr dut48 (
        .clk      (clk),
        .reset    (r48),
        .start    (start48),
        .tx_data  (tx48),
        .busy     (busy_a[1]),
        .done     (done_a[1]),
        .rx_data  (rx48),
        .spi_clk  (sclk_a[1]),
        .spi_mosi (mosi_a[1]),
        .spi_miso (miso48),
        .spi_ss_n (ss_a[1])
`ifdef SPI_LATCH_EN
        ,
        .spi_latch (latch48)
`endif
    );

    // Behavioural shiftreg: shifts MOSI in on spi_clk rise, MSB drives MISO,
    // parallel output latched when slave select rises.
    initial begin
        chain = '0;
        forever begin
            @(posedge sclk_a[1] or posedge chain_ld);
            if (chain_ld) chain = chain_val;
            else          chain = {chain[46:0], mosi_a[1]};
        end
    end

    initial begin
        regout = '0;
        forever begin
            @(posedge ss_a[1]);
            regout = chain;
        end
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk($sformatf("%s_sclk%0d", tag, i), 48'(sclk_a[i]), 48'd0);
        chk($sformatf("%s_ss%0d",   tag, i), 48'(ss_a[i]),   48'd1);
        chk($sformatf("%s_mosi%0d", tag, i), 48'(mosi_a[i]), 48'd0);
        chk($sformatf("%s_busy%0d", tag, i), 48'(busy_a[i]), 48'd0);
        chk($sformatf("%s_done%0d", tag, i), 48'(done_a[i]), 48'd0);
        chk($sformatf("%s_rx%0d",   tag, i), rx_a[i],        48'd0);
    endtask

    task automatic wait_done(input int i, input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done_a[i] !== 1'b1 && n < budget);
        chk($sformatf("%s_done_seen", name), 48'(done_a[i]), 48'd1);
    endtask

    // Monitor: per-frame measurement, scoreboard pop on every done pulse.
    initial begin
        logic        prev_ss   [2];
        logic        prev_sclk [2];
        int          low_cnt   [2];
        int          edges     [2];
        logic [47:0] pat       [2];
        exp_t        e;
        for (int i = 0; i < 2; i++) begin
            prev_ss[i] = 1'b1; prev_sclk[i] = 1'b0;
            low_cnt[i] = 0; edges[i] = 0; pat[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (ss_a[i] === 1'b1 && sclk_a[i] === 1'b1) clk_viol++;
                if (ss_a[i] === 1'b0) begin
                    if (prev_ss[i] === 1'b1) begin
                        low_cnt[i] = 0; edges[i] = 0; pat[i] = '0;
                    end
                    low_cnt[i]++;
                    if (sclk_a[i] === 1'b1 && prev_sclk[i] === 1'b0) begin
                        edges[i]++;
                        pat[i] = {pat[i][46:0], mosi_a[i]};
                    end
                end
                if (done_a[i] === 1'b1) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        chk($sformatf("unexpected_done%0d", i), 48'(done_a[i]), 48'd0);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("rx_data%0d", i),  rx_a[i],          e.rx);
                        chk($sformatf("mosi_pat%0d", i), pat[i],           e.pat);
                        chk($sformatf("ss_low%0d", i),   48'(low_cnt[i]),  48'(e.low));
                        chk($sformatf("sclk_rises%0d", i), 48'(edges[i]),  48'(e.edges));
                        if (i == 1) chk("regout", regout, e.reg_o);
                    end
                end
                prev_ss[i]   = ss_a[i];
                prev_sclk[i] = sclk_a[i];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, cnt;
        logic p;
        r8 = 1'b0; r48 = 1'b0; start8 = 1'b0; start48 = 1'b0;
        tx8 = '0; tx48 = '0; chain_val = '0;

        // Reset held for 5 edges, then idle with no start.
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk_idle(0, "rst");
            chk_idle(1, "rst");
            if (k == 4) begin
                r8 = 1'b1; r48 = 1'b1;
            end
        end

        // Single 8-bit loopback frame.
        q0.push_back('{rx: 48'hA5, pat: 48'hA5, reg_o: 48'h0, low: 34, edges: 8});
        tx8 = 8'hA5; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; tx8 = 8'h00;
        wait_done(0, 200, "a5");
        chk("gap0_busy", 48'(busy_a[0]), 48'd0);

        // Back-to-back with start held high and no gap.
        q0.push_back('{rx: 48'h3C, pat: 48'h3C, reg_o: 48'h0, low: 34, edges: 8});
        q0.push_back('{rx: 48'h3C, pat: 48'h3C, reg_o: 48'h0, low: 34, edges: 8});
        tx8 = 8'h3C; start8 = 1'b1;
        wait_done(0, 200, "b2b1");
        chk("b2b_ss_high", 48'(ss_a[0]), 48'd1);
        @(negedge clk);
        chk("b2b_ss_restart", 48'(ss_a[0]), 48'd0);
        start8 = 1'b0;
        wait_done(0, 200, "b2b2");

        // Reset while spi_clk is high with bit_cnt=20 (28th rising edge).
        tx48 = 48'hC3C3_C3C3_C3C3; start48 = 1'b1;
        @(negedge clk);
        start48 = 1'b0;
        n = 0; cnt = 0; p = 1'b0;
        while (cnt < 28 && n < 3000) begin
            @(negedge clk);
            n++;
            if (sclk_a[1] === 1'b1 && p === 1'b0) cnt++;
            p = sclk_a[1];
        end
        chk("abort_reach", 48'(cnt), 48'd28);
        r48 = 1'b0;
        @(negedge clk);
        chk_idle(1, "abort");
        @(negedge clk);
        r48 = 1'b1;
        chk_idle(1, "abort_hold");

        // Clean 48-bit frame into the shiftreg model.
        chain_val = 48'hA1B2_C3D4_E5F6; chain_ld = 1'b1;
        @(negedge clk);
        chain_ld = 1'b0;
        q1.push_back('{rx: 48'hA1B2_C3D4_E5F6, pat: 48'h01FF_FFFF_FFFF,
                       reg_o: 48'h01FF_FFFF_FFFF, low: 388, edges: 48});
        tx48 = 48'h01FF_FFFF_FFFF; start48 = 1'b1;
        @(negedge clk);
        start48 = 1'b0; tx48 = 48'hDEAD_BEEF_0000;
        wait_done(1, 1000, "f48");
        n = 0;
        while (busy_a[1] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("f48_idle", 48'(busy_a[1]), 48'd0);

        // Start ignored mid-frame and during the gap.
        q1.push_back('{rx: 48'h01FF_FFFF_FFFF, pat: 48'h5A5A_00FF_1234,
                       reg_o: 48'h5A5A_00FF_1234, low: 388, edges: 48});
        tx48 = 48'h5A5A_00FF_1234; start48 = 1'b1;
        @(negedge clk);
        start48 = 1'b0;
        repeat (100) @(negedge clk);
        tx48 = 48'hFFFF_0000_FFFF; start48 = 1'b1;
        @(negedge clk);
        start48 = 1'b0;
        wait_done(1, 1000, "busy_frame");
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start48 = (n == 3);
        end while (busy_a[1] !== 1'b0 && n < 50);
        start48 = 1'b0;
        chk("busy_fall_after_done", 48'(n), 48'd8);
        repeat (30) @(negedge clk);
        chk("no_queued_ss", 48'(ss_a[1]), 48'd1);
        chk("no_queued_busy", 48'(busy_a[1]), 48'd0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 48'(q0.size() + q1.size()), 48'd0);
        chk("sclk_while_ss_high", 48'(clk_viol), 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
